instr_align_decoder: RTL and testbench
======================================

Name: instr_align_decoder

Overview:
- Front-end stage between instruction fetch and execute.
- Accepts fixed-width fetch beats of halfwords and buffers them in a circular halfword queue.
- Splits the stream into 16/32/48-bit instructions by the group field, assembles each one, and presents it through a registered valid/ready output.
- Each output carries its PC, length and fully decoded fields, and the block supports flush/redirect to an arbitrary halfword-aligned PC.

Parameters:
- FETCH_HW, 2: halfwords per fetch beat. Legal values 1, 2, 4.
- Q_DEPTH, 8: halfword queue depth. Must be a power of two and at least FETCH_HW+2; violation is an elaboration error.
- PC_W, 32: PC width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered/pending state. The next accepted beat carries the new PC.
- fetch_valid  in  1  fetch beat valid.
- fetch_ready  out  1  block can accept a beat.
- fetch_data  in  16*FETCH_HW  beat. Halfword 0 is in the MS bits (lowest address).
- fetch_pc  in  PC_W  address of the first useful halfword. Sampled only on the first beat after reset or flush.
- out_valid  out  1  instruction available.
- out_ready  in  1  consumer accepts the instruction.
- out_pc  out  PC_W  address of the instruction.
- out_len  out  2  instruction length in halfwords: 1, 2 or 3.
- out_instr  out  48  assembled instruction, left-justified ({hw0,hw1,hw2}). Unused halfwords are 0.
- out_fields  out  $bits(instr_fields_t)  decoded fields of out_instr.

Behaviour:
- Reset (rst=1 at edge): queue empty, count=0, state AWAIT_PC. out_valid=0, out_pc=0, out_len=0, out_instr=0, out_fields='0. fetch_ready=0 while rst=1.
- Priority: rst > flush > normal operation.
- fetch_ready = !rst && !flush && (count <= Q_DEPTH-FETCH_HW). It depends only on registered state, so there is no combinational path from out_ready.
- Beat accepted at an edge where fetch_valid && fetch_ready.
  - In RUN state: all FETCH_HW halfwords are pushed.
  - In AWAIT_PC state: the leading skip = fetch_pc[$clog2(FETCH_HW):1] halfwords are dropped, the remainder is pushed, pc_q is loaded with fetch_pc, and the state goes to RUN.
  - For FETCH_HW=1, skip=0.
- Length of the head halfword, from group bits [15:14]: 00→1, 01→2, 10→2, 11→3.
- Output load: at an edge where (!out_valid || out_ready) && state==RUN && count >= len(head):
  - pop len halfwords;
  - register out_instr (zero-filled), out_len, out_pc=pc_q and out_fields;
  - set out_valid=1;
  - pc_q += 2*len, modulo 2^PC_W.
- If out_valid && out_ready and no new load occurs, out_valid falls to 0.
- While out_valid && !out_ready, all out_* signals hold stable.
- A partial instruction at the head (count < len) is never emitted; the block waits for more beats.
- Push and pop in the same cycle are allowed; count_next = count + pushed - popped.
- Head/tail pointers wrap modulo Q_DEPTH.
- Latency: beat accepted at edge E0; the instruction can be loaded at E1, so out_valid is high after E1 (2 edges from fetch handshake with an empty queue).
- Throughput: at most one instruction per cycle.
- flush=1 at an edge: count=0, pointers=0, out_valid=0, state=AWAIT_PC. Any beat presented in the same cycle is ignored (fetch_ready=0), and out_pc/out_instr/out_fields keep their values. Flush during a straddled 48-bit instruction drops the partial halfwords.
- out_fields decode (combinational from the assembled value, then registered):
  - group, flag bit, oper, ra and rb from hw0;
  - rc, rd, re and rf from hw1; rg and rh from hw2;
  - rx from hw1[7:4] if group==2, else from hw2[7:4];
  - imm2 from hw1[1:0] if group==2, else from hw2[1:0];
  - u16 is zero-extended hw1;
  - s16 and s12 are sign-extended by their MSB (bit 15 and bit 11 of hw1);
  - imm32 = {hw1,hw2}.

Decomposition:
- pkg_cpu adds:
  - instr_fields_t (packed struct of all decoded fields);
  - instr_group_t enum;
  - function instr_len_hw(group);
  - HW_W=16 and INSTR_MAX_W=48 constants.
- One combinational sub-module, instr_fields_decode (48-bit in, instr_fields_t out), instantiated once on the assembled instruction.
- Queue, state machine and output register live in the top module.

Test Plan:
- Reset, then beat fetch_pc=0x100, data {0x0123,0x0456} → two outputs, in order:
  - pc=0x100, len=1, instr=0x0123_0000_0000;
  - pc=0x102, len=1, instr=0x0456_0000_0000.
- 48-bit straddle across beats, pc=0x200:
  - beats {0xC1AB,0x1234}, then {0x5678,0x0001};
  - first output: pc=0x200, len=3, instr=0xC1AB_1234_5678, imm32=0x12345678, ra=0xA, rb=0xB;
  - no out_valid before the second beat arrives;
  - then pc=0x206, len=1.
- Redirect alignment: after flush, beat fetch_pc=0x302, data {0xFFFF,0x0105} → 0xFFFF is dropped; single output pc=0x302, len=1, instr=0x0105_0000_0000.
- Backpressure with out_ready=0 and continuous group-0 beats:
  - fetch_ready deasserts once count reaches 7 (>6 for Q_DEPTH=8, FETCH_HW=2);
  - out_* stay stable;
  - raising out_ready drains the instructions in PC order with no loss or duplication.
- Flush mid-instruction: halfwords {0xC000,0x1111} queued, then flush → out_valid=0 and fetch_ready=0 that cycle, count=0. A new beat with fetch_pc=0x400 restarts with out_pc=0x400.
- Sign extension: group-2 instruction {0x8012,0x0800} → imm_s12=0xFFFFF800, imm_s16=0x00000800, rc=0, rd=8, rx=0.

Source files
------------

// File: rtl/instr_align_decoder_pkg.sv
// Shared types and helpers for the instruction align/decode front-end.
`default_nettype none

package instr_align_decoder_pkg;

  localparam int HW_W        = 16;
  localparam int INSTR_MAX_W = 48;

  typedef enum logic [1:0] {
    GRP_16  = 2'b00,
    GRP_32A = 2'b01,
    GRP_32B = 2'b10,
    GRP_48  = 2'b11
  } instr_group_t;

  typedef struct packed {
    instr_group_t group;
    logic         flag;
    logic [4:0]   oper;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    logic [3:0]   rd;
    logic [3:0]   re;
    logic [3:0]   rf;
    logic [3:0]   rg;
    logic [3:0]   rh;
    logic [3:0]   rx;
    logic [1:0]   imm2;
    logic [31:0]  imm_u16;
    logic [31:0]  imm_s16;
    logic [31:0]  imm_s12;
    logic [31:0]  imm32;
  } instr_fields_t;

  function automatic logic [1:0] instr_len_hw(input instr_group_t group);
    case (group)
      GRP_16:  instr_len_hw = 2'd1;
      GRP_48:  instr_len_hw = 2'd3;
      default: instr_len_hw = 2'd2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fields_decode.sv
// Combinational field extraction from a left-justified 48-bit instruction.
`default_nettype none

module instr_fields_decode
  import instr_align_decoder_pkg::*;
(
  input  logic [INSTR_MAX_W-1:0] instr,
  output instr_fields_t          fields
);

  logic [HW_W-1:0] hw0, hw1, hw2;
  logic            is_grp2;

  assign hw0     = instr[47:32];
  assign hw1     = instr[31:16];
  assign hw2     = instr[15:0];
  assign is_grp2 = (hw0[15:14] == 2'b10);

  always_comb begin
    fields         = '0;
    fields.group   = instr_group_t'(hw0[15:14]);
    fields.flag    = hw0[13];
    fields.oper    = hw0[12:8];
    fields.ra      = hw0[7:4];
    fields.rb      = hw0[3:0];
    fields.rc      = hw1[15:12];
    fields.rd      = hw1[11:8];
    fields.re      = hw1[7:4];
    fields.rf      = hw1[3:0];
    fields.rg      = hw2[15:12];
    fields.rh      = hw2[11:8];
    // Group 2 has no third halfword, so its rx/imm2 live in hw1.
    fields.rx      = is_grp2 ? hw1[7:4] : hw2[7:4];
    fields.imm2    = is_grp2 ? hw1[1:0] : hw2[1:0];
    fields.imm_u16 = {16'h0, hw1};
    fields.imm_s16 = {{16{hw1[15]}}, hw1};
    fields.imm_s12 = {{20{hw1[11]}}, hw1[11:0]};
    fields.imm32   = {hw1, hw2};
  end

endmodule

`default_nettype wire

// File: rtl/instr_align_decoder.sv
// Buffers fetch beats in a halfword ring, splits them into 16/32/48-bit
// instructions and presents each decoded instruction through a registered valid/ready port.
`default_nettype none

module instr_align_decoder
  import instr_align_decoder_pkg::*;
#(
  parameter int FETCH_HW = 2,
  parameter int Q_DEPTH  = 8,
  parameter int PC_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [HW_W*FETCH_HW-1:0]      fetch_data,
  input  logic [PC_W-1:0]               fetch_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_W-1:0]               out_pc,
  output logic [1:0]                    out_len,
  output logic [INSTR_MAX_W-1:0]        out_instr,
  output logic [$bits(instr_fields_t)-1:0] out_fields
);

  localparam int AW  = $clog2(Q_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SKW = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
  localparam logic [CW-1:0] FREE_LIM = CW'(Q_DEPTH - FETCH_HW);
  localparam logic [CW-1:0] BEAT_HW  = CW'(FETCH_HW);

  generate
    if (FETCH_HW != 1 && FETCH_HW != 2 && FETCH_HW != 4) begin : g_bad_fetch_hw
      $error("FETCH_HW must be 1, 2 or 4");
    end
    if ((Q_DEPTH & (Q_DEPTH - 1)) != 0 || Q_DEPTH < FETCH_HW + 2) begin : g_bad_q_depth
      $error("Q_DEPTH must be a power of two and at least FETCH_HW+2");
    end
  endgenerate

  typedef enum logic [0:0] {
    AWAIT_PC = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t            state;
  logic [HW_W-1:0]   q_mem [Q_DEPTH];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [PC_W-1:0]   pc_q;

  logic [SKW-1:0]    skip, eff_skip;
  logic              accept, load;
  logic [CW-1:0]     push_n, pop_n;
  logic [HW_W-1:0]   hw0, hw1, hw2;
  logic [1:0]        head_len;
  logic [INSTR_MAX_W-1:0] assembled;
  instr_fields_t     dec_fields;

  generate
    if (FETCH_HW == 1) begin : g_skip_none
      assign skip = '0;
    end else begin : g_skip_pc
      assign skip = fetch_pc[SKW:1];
    end
  endgenerate

  // Only registered state feeds fetch_ready, keeping out_ready off this path.
  assign fetch_ready = !rst && !flush && (count <= FREE_LIM);
  assign accept      = fetch_valid && fetch_ready;
  assign eff_skip    = (state == RUN) ? '0 : skip;
  assign push_n      = accept ? (BEAT_HW - CW'(eff_skip)) : '0;

  assign hw0      = q_mem[head];
  assign hw1      = q_mem[head + AW'(1)];
  assign hw2      = q_mem[head + AW'(2)];
  assign head_len = instr_len_hw(instr_group_t'(hw0[15:14]));

  assign load  = (!out_valid || out_ready) && (state == RUN) &&
                 (count >= {{(CW-2){1'b0}}, head_len});
  assign pop_n = load ? {{(CW-2){1'b0}}, head_len} : '0;

  assign assembled = {hw0,
                      (head_len >= 2'd2) ? hw1 : {HW_W{1'b0}},
                      (head_len == 2'd3) ? hw2 : {HW_W{1'b0}}};

  instr_fields_decode u_decode (
    .instr  (assembled),
    .fields (dec_fields)
  );

  // Ring storage needs no reset; only head/tail/count define its contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < FETCH_HW; i++) begin
        if (i >= int'(eff_skip)) begin
          q_mem[tail + AW'(i) - AW'(eff_skip)] <= fetch_data[HW_W*(FETCH_HW-i)-1 -: HW_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AWAIT_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pc_q       <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_len    <= '0;
      out_instr  <= '0;
      out_fields <= '0;
    end else if (flush) begin
      state     <= AWAIT_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      count <= count + push_n - pop_n;
      tail  <= tail + push_n[AW-1:0];
      head  <= head + pop_n[AW-1:0];
      if (accept && state == AWAIT_PC) begin
        state <= RUN;
        pc_q  <= fetch_pc;
      end
      if (load) begin
        out_valid  <= 1'b1;
        out_pc     <= pc_q;
        out_len    <= head_len;
        out_instr  <= assembled;
        out_fields <= dec_fields;
        pc_q       <= pc_q + PC_W'({head_len, 1'b0});
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_align_decoder.sv
// Scoreboard bench for instr_align_decoder (FETCH_HW=2, Q_DEPTH=8).
`default_nettype none
`timescale 1ns/1ps

module tb_instr_align_decoder;
  import instr_align_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_ready, out_valid, out_ready;
  logic [31:0] fetch_data, fetch_pc, out_pc;
  logic [1:0]  out_len;
  logic [47:0] out_instr;
  logic [$bits(instr_fields_t)-1:0] out_fields;
  instr_fields_t f;

  assign f = instr_fields_t'(out_fields);

  always #5 clk = ~clk;

  instr_align_decoder #(.FETCH_HW(2), .Q_DEPTH(8), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_pc    (fetch_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_len     (out_len),
    .out_instr   (out_instr),
    .out_fields  (out_fields)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  len;
    logic [47:0] instr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [1:0] len, input logic [47:0] instr);
    exp_t e;
    e.pc = pc; e.len = len; e.instr = instr;
    return e;
  endfunction

  // Every handshake seen at the negative edge retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got pc=%h len=%0d instr=%h want none", out_pc, out_len, out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_pc !== e.pc || out_len !== e.len || out_instr !== e.instr) begin
          errors++;
          $display("FAIL sb_output got pc=%h len=%0d instr=%h want pc=%h len=%0d instr=%h",
                   out_pc, out_len, out_instr, e.pc, e.len, e.instr);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] pc, input logic [31:0] data);
    bit ok = 0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_data  = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fetch_ready) ok = 1;
    end
    @(posedge clk);
    #1 fetch_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout got fetch_ready=0 want 1 (pc=%h)", pc);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
    fetch_data = '0; fetch_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_len !== 2'd0 || out_instr !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b pc=%h len=%0d instr=%h want all 0", out_valid, out_pc, out_len, out_instr);
    end
    checks++;
    if (out_fields !== '0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0", out_fields);
    end
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch_ready got %b want 0", fetch_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b want 1", fetch_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    sb.push_back(mk(32'h100, 2'd1, 48'h0123_0000_0000));
    sb.push_back(mk(32'h102, 2'd1, 48'h0456_0000_0000));
    send_beat(32'h100, {16'h0123, 16'h0456});
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL latency_first got v=%b pc=%h want v=1 pc=00000100", out_valid, out_pc);
    end
    wait_drain(20);
  endtask

  task automatic test_straddle();
    bit early = 0;
    bit seen  = 0;
    do_flush();
    out_ready = 1'b1;
    sb.push_back(mk(32'h200, 2'd3, 48'hC1AB_1234_5678));
    sb.push_back(mk(32'h206, 2'd1, 48'h0001_0000_0000));
    send_beat(32'h200, {16'hC1AB, 16'h1234});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL straddle_partial got out_valid=1 want 0 before second beat");
    end
    @(posedge clk); #1;
    send_beat(32'h0, {16'h5678, 16'h0001});
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || out_pc !== 32'h200 || f.imm32 !== 32'h1234_5678 || f.ra !== 4'hA || f.rb !== 4'hB) begin
      errors++;
      $display("FAIL straddle_fields got v=%b pc=%h imm32=%h ra=%h rb=%h want v=1 pc=00000200 imm32=12345678 ra=a rb=b",
               seen, out_pc, f.imm32, f.ra, f.rb);
    end
    checks++;
    if (f.rx !== 4'h7 || f.imm2 !== 2'd0 || f.group !== GRP_48) begin
      errors++;
      $display("FAIL straddle_rx got rx=%h imm2=%0d group=%0d want rx=7 imm2=0 group=3", f.rx, f.imm2, f.group);
    end
    wait_drain(20);
  endtask

  task automatic test_redirect();
    do_flush();
    out_ready = 1'b1;
    sb.push_back(mk(32'h302, 2'd1, 48'h0105_0000_0000));
    send_beat(32'h302, {16'hFFFF, 16'h0105});
    wait_drain(20);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int nb = 0;
    do_flush();
    out_ready   = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h500;
    fetch_data  = {16'h0010, 16'h0011};
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (fetch_ready) begin
        @(posedge clk);
        #1;
        sb.push_back(mk(32'h500 + 32'(4*nb), 2'd1, {16'h0010 + 16'(2*nb), 32'h0}));
        sb.push_back(mk(32'h502 + 32'(4*nb), 2'd1, {16'h0011 + 16'(2*nb), 32'h0}));
        nb++;
        fetch_data = {16'h0010 + 16'(2*nb), 16'h0011 + 16'(2*nb)};
      end
    end
    fetch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (nb != 4 || fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill got beats=%0d ready=%b want beats=4 ready=0", nb, fetch_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_len !== 2'd1 || out_instr !== 48'h0010_0000_0000) begin
      errors++;
      $display("FAIL bp_stable got v=%b pc=%h len=%0d instr=%h want v=1 pc=00000500 len=1 instr=001000000000",
               out_valid, out_pc, out_len, out_instr);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(40);
    @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_drain got ready=%b v=%b want ready=1 v=0", fetch_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_mid();
    do_flush();
    out_ready = 1'b1;
    send_beat(32'h600, {16'hC000, 16'h1111});
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_held got out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b want 0", fetch_ready);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_cleared got v=%b ready=%b want v=0 ready=1", out_valid, fetch_ready);
    end
    @(posedge clk); #1;
    sb.push_back(mk(32'h400, 2'd1, 48'h0042_0000_0000));
    sb.push_back(mk(32'h402, 2'd1, 48'h0043_0000_0000));
    send_beat(32'h400, {16'h0042, 16'h0043});
    wait_drain(20);
  endtask

  task automatic test_sign_ext();
    bit seen = 0;
    do_flush();
    out_ready = 1'b1;
    sb.push_back(mk(32'h700, 2'd2, 48'h8012_0800_0000));
    send_beat(32'h700, {16'h8012, 16'h0800});
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || f.imm_s12 !== 32'hFFFF_F800 || f.imm_s16 !== 32'h0000_0800 || f.imm_u16 !== 32'h0000_0800) begin
      errors++;
      $display("FAIL sign_ext got v=%b s12=%h s16=%h u16=%h want v=1 s12=fffff800 s16=00000800 u16=00000800",
               seen, f.imm_s12, f.imm_s16, f.imm_u16);
    end
    checks++;
    if (f.rc !== 4'h0 || f.rd !== 4'h8 || f.rx !== 4'h0 || f.oper !== 5'h0 || f.ra !== 4'h1 || f.rb !== 4'h2) begin
      errors++;
      $display("FAIL grp2_fields got rc=%h rd=%h rx=%h oper=%h ra=%h rb=%h want rc=0 rd=8 rx=0 oper=0 ra=1 rb=2",
               f.rc, f.rd, f.rx, f.oper, f.ra, f.rb);
    end
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_straddle();
    test_redirect();
    test_backpressure();
    test_flush_mid();
    test_sign_ext();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
